// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: instruction decode inputs and datapath control outputs of the main controller
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic zero;
  logic overflow;
  logic pc_wr;
  logic [1:0] npc_sel;
  logic ir_wr;
  logic reg_wr;
  logic [1:0] reg_dst;
  logic [1:0] wb_sel;
  logic [1:0] ext_op;
  logic alu_src_b;
  logic [3:0] alu_op;
  logic mem_wr;
  logic illegal;
  logic [3:0] state;
  modport master (
    input op, funct, zero, overflow,
    output pc_wr, npc_sel, ir_wr, reg_wr, reg_dst, wb_sel, ext_op, alu_src_b, alu_op, mem_wr, illegal, state
  );
  modport slave (
    output op, funct, zero, overflow,
    input pc_wr, npc_sel, ir_wr, reg_wr, reg_dst, wb_sel, ext_op, alu_src_b, alu_op, mem_wr, illegal, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset main controller sequencing fetch/decode/execute/memory/writeback
module mc_ctrl #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input logic clk,
  input logic rst,
  mc_ctrl_if.master bus
);
  typedef enum logic [3:0] {FETCH, DECODE, EXE, AWB, MADDR, MRD, MWB, MWR, BR, JMP, HALT} state_t;
  state_t state, nxt;
  logic ov_q;
  logic r_type, is_addu, is_subu, is_slt, is_jr, is_ori, is_lui, is_addi, is_addiu;
  logic is_lw, is_sw, is_beq, is_j, is_jal, is_alu, is_mem, is_jmp, legal;
  assign r_type   = bus.op == 6'h00;
  assign is_addu  = r_type && bus.funct == 6'h21;
  assign is_subu  = r_type && bus.funct == 6'h23;
  assign is_slt   = r_type && bus.funct == 6'h2a;
  assign is_jr    = r_type && bus.funct == 6'h08;
  assign is_ori   = bus.op == 6'h0d;
  assign is_lui   = bus.op == 6'h0f;
  assign is_addi  = bus.op == 6'h08;
  assign is_addiu = bus.op == 6'h09;
  assign is_lw    = bus.op == 6'h23;
  assign is_sw    = bus.op == 6'h2b;
  assign is_beq   = bus.op == 6'h04;
  assign is_j     = bus.op == 6'h02;
  assign is_jal   = bus.op == 6'h03;
  assign is_alu   = is_addu | is_subu | is_slt | is_ori | is_lui | is_addi | is_addiu;
  assign is_mem   = is_lw | is_sw;
  assign is_jmp   = is_j | is_jal | is_jr;
  assign legal    = is_alu | is_mem | is_beq | is_jmp;
  assign bus.state = state;
  // state register; overflow captured at the end of EXE for the addi writeback decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      ov_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == EXE) ov_q <= bus.overflow;
    end
  end
  // next state and Moore outputs; everything held at 0 while reset is asserted
  always_comb begin
    nxt = state;
    bus.pc_wr = 1'b0;
    bus.npc_sel = 2'b00;
    bus.ir_wr = 1'b0;
    bus.reg_wr = 1'b0;
    bus.reg_dst = 2'b00;
    bus.wb_sel = 2'b00;
    bus.ext_op = 2'b00;
    bus.alu_src_b = 1'b0;
    bus.alu_op = 4'b0000;
    bus.mem_wr = 1'b0;
    bus.illegal = 1'b0;
    case (state)
      FETCH: nxt = DECODE;
      DECODE: nxt = is_alu ? EXE : is_mem ? MADDR : is_beq ? BR : is_jmp ? JMP : ILLEGAL_TRAP ? HALT : FETCH;
      EXE: nxt = AWB;
      MADDR: nxt = is_lw ? MRD : MWR;
      MRD: nxt = MWB;
      HALT: nxt = HALT;
      default: nxt = FETCH;
    endcase
    if (!rst) begin
      case (state)
        FETCH: begin
          bus.ir_wr = 1'b1;
          bus.pc_wr = 1'b1;
        end
        DECODE: bus.illegal = !legal;
        EXE: begin
          bus.alu_op = is_subu ? 4'b0001 : is_slt ? 4'b0110 : is_ori ? 4'b0010 : is_lui ? 4'b0011 : is_addi ? 4'b0101 : 4'b0000;
          bus.alu_src_b = !r_type;
          bus.ext_op = (r_type || is_ori) ? 2'b00 : is_lui ? 2'b10 : 2'b01;
        end
        AWB: begin
          bus.reg_wr = !(is_addi && ov_q);
          bus.reg_dst = r_type ? 2'b01 : 2'b00;
        end
        MADDR: begin
          bus.alu_src_b = 1'b1;
          bus.ext_op = 2'b01;
        end
        MWB: begin
          bus.reg_wr = 1'b1;
          bus.wb_sel = 2'b01;
        end
        MWR: bus.mem_wr = 1'b1;
        BR: begin
          bus.alu_op = 4'b0001;
          bus.npc_sel = 2'b01;
          bus.pc_wr = bus.zero;
        end
        JMP: begin
          bus.pc_wr = 1'b1;
          bus.npc_sel = is_jr ? 2'b11 : 2'b10;
          bus.reg_wr = is_jal;
          bus.reg_dst = is_jal ? 2'b10 : 2'b00;
          bus.wb_sel = is_jal ? 2'b10 : 2'b00;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS-subset datapath.
- Sole producer of the 4-bit ALU operation code and of every datapath write-enable and mux select.
- Decodes op/funct from the instruction register and sequences fetch/decode/execute/memory/writeback states.
- Consumes the ALU zero and overflow flags to qualify branches and signed-add writeback.

Parameters:
- ILLEGAL_TRAP, 0, 1 = an undecoded instruction parks the FSM in HALT until reset; 0 = skip the instruction and return to FETCH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- overflow  in  1  ALU signed-add overflow
- pc_wr  out  1  PC write enable
- npc_sel  out  2  next-PC source: 00 pc+4, 01 branch, 10 jump target, 11 register rs
- ir_wr  out  1  IR write enable
- reg_wr  out  1  register file write enable
- reg_dst  out  2  destination register: 00 rt, 01 rd, 10 $31
- wb_sel  out  2  writeback data: 00 ALUOut, 01 MDR, 10 pc (already pc+4)
- ext_op  out  2  immediate extender: 00 zero-extend, 01 sign-extend, 10 imm<<16
- alu_src_b  out  1  ALU B operand: 0 register B, 1 extended immediate
- alu_op  out  4  0000 Addu, 0001 Subu, 0010 Or, 0011 pass-B, 0100 pass-A, 0101 Add (signed, overflow), 0110 Lt
- mem_wr  out  1  data memory write enable
- illegal  out  1  one-cycle pulse in DECODE on an undecoded instruction
- state  out  4  current state, for debug

Behaviour:
- States: FETCH, DECODE, EXE, AWB, MADDR, MRD, MWB, MWR, BR, JMP, HALT.
- Outputs are Moore-style functions of the state, plus the op/funct decode.
- Outside the states listed below, all enables are 0, all selects are 0 and alu_op is Addu.
- Reset (asynchronous):
  - state goes to FETCH immediately.
  - While rst is high, every output is forced to 0, including FETCH's pc_wr and ir_wr.
  - The internal overflow latch ov_q is cleared.
  - After reset deasserts, the first rising clock edge performs the fetch.
- FETCH: ir_wr=1, pc_wr=1, npc_sel=00. Next state is DECODE.
- DECODE: all enables 0. Next state by class:
  - R-type addu/subu/slt, ori, lui, addi, addiu → EXE.
  - lw, sw → MADDR.
  - beq → BR.
  - j, jal, jr (R-type funct 001000) → JMP.
  - Any other op/funct: illegal=1; next state is HALT if ILLEGAL_TRAP, else FETCH.
- EXE: alu_op per instruction: addu→Addu, subu→Subu, slt→Lt, ori→Or, lui→pass-B, addi→Add, addiu→Addu.
  - alu_src_b=1 for I-type instructions.
  - ext_op: ori 00, lui 10, addi/addiu 01.
  - ov_q ← overflow. ov_q is only meaningful for addi.
  - Next state is AWB.
- AWB:
  - reg_wr=1, wb_sel=00.
  - reg_dst=01 for R-type, 00 for I-type.
  - For addi with ov_q=1: reg_wr=0, so no destination write occurs.
  - Next state is FETCH.
- MADDR: alu_op=Addu, alu_src_b=1, ext_op=01. Next state is MRD for lw, MWR for sw.
- MRD: memory read into MDR (no enable). Next state is MWB.
- MWB: reg_wr=1, reg_dst=00, wb_sel=01. Next state is FETCH.
- MWR: mem_wr=1. Next state is FETCH.
- BR: alu_op=Subu, alu_src_b=0, npc_sel=01, pc_wr=zero. Next state is FETCH.
- JMP: pc_wr=1; npc_sel=10 for j/jal, 11 for jr.
  - jal additionally asserts reg_wr=1, reg_dst=10, wb_sel=10. pc still holds pc+4 at this point.
  - Next state is FETCH.
- HALT: all enables 0; stays in HALT until rst.
- Latencies in cycles: R/ori/lui/addi/addiu 4, lw 5, sw 4, beq 3, j/jal/jr 3.
- Simultaneous events: op/funct are sampled only in DECODE/EXE/AWB/MADDR/JMP. IR is stable in these states because ir_wr is asserted only in FETCH.
- Reset mid-instruction (e.g. in MWR or AWB) aborts with no partial write, because the enables drop asynchronously.

Test Plan:
- rst pulse mid-MWR of sw → mem_wr falls to 0 within the same cycle; state=FETCH; after release, first edge fetches with pc_wr=ir_wr=1.
- addu (op 000000, funct 100001) → state sequence FETCH, DECODE, EXE, AWB, FETCH; alu_op=0000 in EXE; AWB reg_wr=1, reg_dst=01, wb_sel=00.
- addi (op 001000), overflow=1 in EXE → AWB reg_wr=0; repeat with overflow=0 → reg_wr=1, reg_dst=00, ext_op=01, alu_op=0101.
- lw (op 100011) → 5 cycles; MADDR alu_op=0000, alu_src_b=1; MWB wb_sel=01; sw (op 101011) → mem_wr=1 only in MWR, 4 cycles.
- beq (op 000100) with zero=1 → BR pc_wr=1, npc_sel=01; with zero=0 → pc_wr=0; both return to FETCH after 3 cycles.
- jal (op 000011) → JMP pc_wr=1, npc_sel=10, reg_wr=1, reg_dst=10, wb_sel=10; op 111111 with ILLEGAL_TRAP=1 → illegal pulse, state stays HALT for 10 cycles.
